// File: rtl/branch_counter_table.sv
// gshare pattern history table: 2**BPRED_WIDTH two-bit saturating counters
// indexed by PC xor global history. Predictions are read combinationally in
// DEC and counters are retrained when a branch resolves in EX. After reset,
// an init FSM sweeps the whole array to INIT_STATE, one entry per cycle.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_INIT    | clearing table[init_ptr] each cycle; predictions forced to 0,
//            | EX updates dropped
// ST_READY   | table live: predictions valid, EX updates applied
module branch_counter_table #(
    parameter int         BPRED_WIDTH = 9,
    parameter int         PC_WIDTH    = 32,
    parameter logic [1:0] INIT_STATE  = 2'b01
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_DEC_Is_Branch,
    input  logic [PC_WIDTH-1:0]    i_DEC_PC,
    input  logic [BPRED_WIDTH-1:0] i_Global_History,
    output logic                   o_Prediction,
    output logic [BPRED_WIDTH-1:0] o_Index,
    input  logic                   i_ALU_Branch_Valid,
    input  logic                   i_ALU_Branch_Outcome,
    input  logic [BPRED_WIDTH-1:0] i_ALU_Index,
    output logic                   o_Ready
);

    localparam int DEPTH = 2 ** BPRED_WIDTH;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [BPRED_WIDTH-1:0] init_ptr_q;
    logic                   ready_q;
    logic [1:0]             table_q [DEPTH];

    logic                   upd_en;
    logic [1:0]             upd_cur;
    logic [1:0]             upd_val;

    // i_DEC_Is_Branch only qualifies the prediction for downstream consumers;
    // the PC bits outside the index window do not take part in hashing.
    logic unused_sig;
    assign unused_sig = ^{i_DEC_Is_Branch,
                          i_DEC_PC[PC_WIDTH-1:BPRED_WIDTH+2],
                          i_DEC_PC[1:0]};

    assign o_Index      = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History;
    assign o_Prediction = ready_q & table_q[o_Index][1];
    assign o_Ready      = ready_q;

    // Outcome/index are only looked at when the EX branch is valid, so X on
    // them cannot reach the array.
    assign upd_en = (state_q == ST_READY) && i_ALU_Branch_Valid;

    // Saturating increment/decrement of the counter addressed by EX.
    always_comb begin
        upd_cur = table_q[i_ALU_Index];
        upd_val = upd_cur;
        if (i_ALU_Branch_Outcome) begin
            if (upd_cur != 2'b11) upd_val = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_val = upd_cur - 2'd1;
        end
    end

    // Init sequencer: sweep init_ptr across the table, then raise ready.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_ptr_q <= init_ptr_q + 1'b1;
                    if (init_ptr_q == {BPRED_WIDTH{1'b1}}) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    state_q <= ST_READY;
                end
                default: begin
                    state_q    <= ST_INIT;
                    init_ptr_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    // Counter array: init writes during INIT, retraining writes in READY.
    // Writes land on the edge, so a same-cycle read sees the old value.
    always_ff @(posedge i_Clk) begin
        if (state_q == ST_INIT) begin
            table_q[init_ptr_q] <= INIT_STATE;
        end else if (upd_en) begin
            table_q[i_ALU_Index] <= upd_val;
        end
    end

endmodule

// File: tb/tb_branch_counter_table.sv
// Bench for branch_counter_table: table-driven index vectors, hand-written
// corner sequences and a randomized phase against a counter-array model.
module tb_branch_counter_table;

    localparam int BW    = 9;
    localparam int DEPTH = 512;

    logic          i_Clk = 1'b0;
    logic          i_Reset;
    logic          i_DEC_Is_Branch;
    logic [31:0]   i_DEC_PC;
    logic [BW-1:0] i_Global_History;
    logic          o_Prediction;
    logic [BW-1:0] o_Index;
    logic          i_ALU_Branch_Valid;
    logic          i_ALU_Branch_Outcome;
    logic [BW-1:0] i_ALU_Index;
    logic          o_Ready;

    branch_counter_table #(.BPRED_WIDTH(BW), .PC_WIDTH(32), .INIT_STATE(2'b01)) dut (
        .i_Clk                (i_Clk),
        .i_Reset              (i_Reset),
        .i_DEC_Is_Branch      (i_DEC_Is_Branch),
        .i_DEC_PC             (i_DEC_PC),
        .i_Global_History     (i_Global_History),
        .o_Prediction         (o_Prediction),
        .o_Index              (o_Index),
        .i_ALU_Branch_Valid   (i_ALU_Branch_Valid),
        .i_ALU_Branch_Outcome (i_ALU_Branch_Outcome),
        .i_ALU_Index          (i_ALU_Index),
        .o_Ready              (o_Ready)
    );

    always #5 i_Clk = ~i_Clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: counters as plain integers, readiness from elapsed cycles.
    int model_cnt [DEPTH];
    int model_since_release;
    bit model_ready;

    typedef struct {
        logic [31:0]   pc;
        logic [BW-1:0] ghr;
        logic [BW-1:0] exp_idx;
    } idx_vec_t;

    idx_vec_t idx_vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int exp_index(input logic [31:0] pc, input logic [BW-1:0] ghr);
        return ((int'(pc) >>> 2) & (DEPTH - 1)) ^ int'(ghr);
    endfunction

    // Compare all outputs against the model for the currently driven inputs.
    task automatic check_outputs(input string name);
        int idx;
        #1;
        idx = exp_index(i_DEC_PC, i_Global_History);
        chk({name, "_idx"},   int'(o_Index), idx);
        chk({name, "_ready"}, int'(o_Ready), int'(model_ready));
        chk({name, "_pred"},  int'(o_Prediction),
            (model_ready && model_cnt[idx] >= 2) ? 1 : 0);
    endtask

    // One clock edge; the model sees the same inputs the DUT samples.
    task automatic tick();
        bit            rst, v, o;
        logic [BW-1:0] ai;
        bit            was_ready;
        rst = i_Reset; v = i_ALU_Branch_Valid; o = i_ALU_Branch_Outcome; ai = i_ALU_Index;
        @(posedge i_Clk);
        was_ready = model_ready;
        if (rst) begin
            foreach (model_cnt[k]) model_cnt[k] = 1;
            model_since_release = 0;
            model_ready = 0;
        end else begin
            if (was_ready && v) begin
                if (o) model_cnt[ai] = (model_cnt[ai] >= 3) ? 3 : model_cnt[ai] + 1;
                else   model_cnt[ai] = (model_cnt[ai] <= 0) ? 0 : model_cnt[ai] - 1;
            end
            if (model_since_release < DEPTH) model_since_release++;
            model_ready = (model_since_release >= DEPTH);
        end
        @(negedge i_Clk);
    endtask

    task automatic set_read(input int idx);
        i_DEC_PC         = 32'(idx) << 2;
        i_Global_History = '0;
    endtask

    // Count cycles until o_Ready, checking predictions stay 0 meanwhile.
    task automatic wait_ready(input string name, input int exp_cycles);
        int n = 0;
        #1;
        while (!o_Ready && n < 2000) begin
            if (n % 64 == 0) begin
                i_DEC_PC = $urandom;
                i_Global_History = BW'($urandom);
                #1;
                chk({name, "_pred_in_init"}, int'(o_Prediction), 0);
            end
            tick();
            #1;
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    initial begin
        int target;
        int exp_sat [7];
        int sel [3];

        idx_vecs[0] = '{32'h0000_0404, 9'h0F0, 9'h1F1};
        idx_vecs[1] = '{32'h0000_0000, 9'h000, 9'h000};
        idx_vecs[2] = '{32'hFFFF_FFFF, 9'h000, 9'h1FF};
        idx_vecs[3] = '{32'h0000_07FC, 9'h1FF, 9'h000};
        idx_vecs[4] = '{32'h0000_0800, 9'h001, 9'h001};
        idx_vecs[5] = '{32'h0000_0003, 9'h0AA, 9'h0AA};
        idx_vecs[6] = '{32'h0000_0154, 9'h000, 9'h055};
        exp_sat = '{1, 1, 1, 1, 0, 0, 0};
        sel = '{201, 300, 511};

        i_Reset = 1'b1;
        i_DEC_Is_Branch = 1'b1;
        i_DEC_PC = '0;
        i_Global_History = '0;
        i_ALU_Branch_Valid = 1'b0;
        i_ALU_Branch_Outcome = 1'b0;
        i_ALU_Index = '0;
        foreach (model_cnt[k]) model_cnt[k] = 1;
        model_since_release = 0;
        model_ready = 0;
        @(negedge i_Clk);

        // Power-on: 2 reset cycles, then a full 512-cycle init sweep.
        tick(); tick();
        #1 chk("reset_ready", int'(o_Ready), 0);
        i_Reset = 1'b0;
        wait_ready("init_len", 512);
        for (int i = 0; i < 16; i++) begin
            i_DEC_PC = $urandom;
            i_Global_History = BW'($urandom);
            #1 chk("post_init_pred", int'(o_Prediction), 0);
        end

        // Index hashing vectors.
        foreach (idx_vecs[i]) begin
            i_DEC_PC = idx_vecs[i].pc;
            i_Global_History = idx_vecs[i].ghr;
            #1 chk($sformatf("index_vec%0d", i), int'(o_Index), int'(idx_vecs[i].exp_idx));
        end

        // Saturation at 0x1F1: 3 taken then 4 not-taken.
        i_DEC_PC = 32'h0000_0404;
        i_Global_History = 9'h0F0;
        i_ALU_Branch_Valid = 1'b1;
        i_ALU_Index = 9'h1F1;
        for (int i = 0; i < 7; i++) begin
            i_ALU_Branch_Outcome = (i < 3);
            tick();
            #1 chk($sformatf("sat_step%0d", i), int'(o_Prediction), exp_sat[i]);
            check_outputs("sat_model");
        end
        i_ALU_Branch_Valid = 1'b0;

        // Same-cycle read and taken update at 0x055: no bypass.
        i_DEC_PC = 32'h0000_0154;
        i_Global_History = 9'h000;
        i_ALU_Branch_Valid = 1'b1;
        i_ALU_Branch_Outcome = 1'b1;
        i_ALU_Index = 9'h055;
        #1 chk("same_cycle_old", int'(o_Prediction), 0);
        tick();
        i_ALU_Branch_Valid = 1'b0;
        #1 chk("same_cycle_new", int'(o_Prediction), 1);

        // Reset in the middle of init restarts the full sweep.
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        repeat (200) tick();
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        wait_ready("reinit_len", 512);
        i_DEC_PC = 32'h0000_0154;
        i_Global_History = 9'h000;
        #1 chk("reinit_0x055_cleared", int'(o_Prediction), 0);
        foreach (sel[i]) begin
            set_read(sel[i]);
            #1 chk($sformatf("reinit_e%0d_pre", sel[i]), int'(o_Prediction), 0);
            i_ALU_Branch_Valid = 1'b1;
            i_ALU_Branch_Outcome = 1'b1;
            i_ALU_Index = BW'(sel[i]);
            tick();
            i_ALU_Branch_Valid = 1'b0;
            #1 chk($sformatf("reinit_e%0d_post", sel[i]), int'(o_Prediction), 1);
        end

        // Update during init is dropped; X on idle EX inputs is harmless.
        i_Reset = 1'b1;
        tick();
        i_Reset = 1'b0;
        repeat (10) tick();
        i_ALU_Branch_Valid = 1'b1;
        i_ALU_Branch_Outcome = 1'b1;
        i_ALU_Index = 9'h003;
        tick();
        i_ALU_Branch_Valid = 1'b0;
        i_ALU_Branch_Outcome = 1'bx;
        i_ALU_Index = 'x;
        wait_ready("init_drop_len", 501);
        set_read(3);
        #1 chk("init_drop_e3", int'(o_Prediction), 0);
        repeat (5) tick();
        #1 chk("x_idle_e3", int'(o_Prediction), 0);
        i_ALU_Branch_Valid = 1'b1;
        i_ALU_Branch_Outcome = 1'b1;
        i_ALU_Index = 9'h003;
        tick();
        i_ALU_Branch_Valid = 1'b0;
        i_ALU_Branch_Outcome = 1'bx;
        i_ALU_Index = 'x;
        #1 chk("e3_was_weak_nt", int'(o_Prediction), 1);
        repeat (5) tick();
        #1 chk("x_idle_e3_hold", int'(o_Prediction), 1);
        i_ALU_Branch_Outcome = 1'b0;
        i_ALU_Index = '0;

        // Randomized traffic concentrated on a few entries.
        for (int c = 0; c < 1500; c++) begin
            target = $urandom_range(0, 15);
            i_DEC_PC = $urandom;
            i_Global_History = BW'(exp_index(i_DEC_PC, 9'h000) ^ target);
            i_ALU_Branch_Valid = ($urandom_range(0, 3) != 0);
            i_ALU_Branch_Outcome = $urandom_range(0, 1) == 1;
            i_ALU_Index = BW'($urandom_range(0, 15));
            check_outputs("rand");
            tick();
        end
        i_ALU_Branch_Valid = 1'b0;
        check_outputs("rand_final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
